// File: rtl/hamming_pkg.sv
// Shared constants for the Hamming(16,11) SECDED encode sequencer.
// Holds the ALU op codes, the sequencer state codes and the parity bit slots.
package hamming_pkg;

  // ALU command codes driven on alu_op
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_P0  = 4'b1000;
  localparam logic [3:0] OP_P1  = 4'b1001;
  localparam logic [3:0] OP_P2  = 4'b1010;
  localparam logic [3:0] OP_P4  = 4'b1011;
  localparam logic [3:0] OP_P8  = 4'b1100;
  localparam logic [3:0] OP_PKL = 4'b1101;
  localparam logic [3:0] OP_PKH = 4'b1110;

  // Sequencer states, one ALU op per state
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_P1   = 4'd1;
  localparam state_t ST_P2   = 4'd2;
  localparam state_t ST_P4   = 4'd3;
  localparam state_t ST_P8   = 4'd4;
  localparam state_t ST_PKL  = 4'd5;
  localparam state_t ST_PKH  = 4'd6;
  localparam state_t ST_P0   = 4'd7;
  localparam state_t ST_DONE = 4'd8;

  // Parity bit slots: P0/P1/P2/P4 in the LSW, P8 in the MSW
  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 0;

endpackage

// File: rtl/hamming_ref_enc.sv
// Purely combinational golden Hamming(16,11) SECDED encoder.
// Codeword position k holds bit k of {enc_msw, enc_lsw}; parity bits sit at
// positions 1, 2, 4, 8 and the overall parity at position 0.
module hamming_ref_enc (
  input  logic [7:0] lsw,
  input  logic [2:0] msw,
  output logic [7:0] enc_lsw,
  output logic [7:0] enc_msw
);

  logic [10:0] d;
  logic        p0, p1, p2, p4, p8;

  // Parity equations follow the data bit placement in the codeword
  always_comb begin
    d  = {msw, lsw};
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    p8 = ^d[10:4];
    p0 = (^d) ^ p1 ^ p2 ^ p4 ^ p8;
    enc_lsw = {d[3], d[2], d[1], p4, d[0], p2, p1, p0};
    enc_msw = {d[10:4], p8};
  end

endmodule

// File: rtl/hamming_enc_seq.sv
// Hamming SECDED encode sequencer driving an external shared 8-bit ALU.
// Walks P1, P2, P4, P8, PKL, PKH, P0 (one ALU op per cycle), then pulses done.
// Optional build macro SEQ_SELFCHECK_EN adds a reference encoder that flags a
// mismatch on chk_err during the done cycle; otherwise chk_err is tied low.
module hamming_enc_seq
  import hamming_pkg::*;
#(
  parameter bit ACCEPT_IN_DONE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] msg_lsw,
  input  logic [7:0] msg_msw,
  output logic       busy,
  output logic       done,
  output logic [7:0] enc_lsw,
  output logic [7:0] enc_msw,
  output logic       chk_err,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sc_in,
  input  logic [7:0] alu_rslt
);

  state_t     state_q, state_d;
  logic [7:0] l_q;
  logic [2:0] m_q;
  logic       p1_q, p2_q, p4_q, p8_q;
  logic [7:0] enc_lsw_q, enc_msw_q;
  logic [7:0] m_ext;
  logic [7:0] pkl_word, pkh_word;
  logic       accept;

  // Message bits above d10 are don't-care
  logic unused_msw;
  assign unused_msw = ^msg_msw[7:3];

  assign m_ext  = {5'b0, m_q};
  assign accept = start &&
                  ((state_q == ST_IDLE) || (ACCEPT_IN_DONE && (state_q == ST_DONE)));

  // Next-state: fixed op walk, optional re-entry straight from DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_P1;
      ST_P1:   state_d = ST_P2;
      ST_P2:   state_d = ST_P4;
      ST_P4:   state_d = ST_P8;
      ST_P8:   state_d = ST_PKL;
      ST_PKL:  state_d = ST_PKH;
      ST_PKH:  state_d = ST_P0;
      ST_P0:   state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_P1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU command per state; operands are zero whenever the sequencer is idle
  always_comb begin
    alu_op = OP_NOP;
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    case (state_q)
      ST_P1:  begin alu_op = OP_P1;  alu_a = l_q;       alu_b = m_ext;     end
      ST_P2:  begin alu_op = OP_P2;  alu_a = l_q;       alu_b = m_ext;     end
      ST_P4:  begin alu_op = OP_P4;  alu_a = l_q;       alu_b = m_ext;     end
      ST_P8:  begin alu_op = OP_P8;  alu_a = l_q;       alu_b = m_ext;     end
      ST_PKL: begin alu_op = OP_PKL; alu_a = l_q;       alu_b = 8'h00;     end
      ST_PKH: begin alu_op = OP_PKH; alu_a = l_q;       alu_b = m_ext;     end
      ST_P0:  begin alu_op = OP_P0;  alu_a = enc_lsw_q; alu_b = enc_msw_q; end
      default: ;
    endcase
  end

  // Pack results: parity slots from the ALU are never trusted, always overwritten
  always_comb begin
    pkl_word         = alu_rslt;
    pkl_word[POS_P4] = p4_q;
    pkl_word[POS_P2] = p2_q;
    pkl_word[POS_P1] = p1_q;
    pkl_word[POS_P0] = 1'b0;
    pkh_word         = alu_rslt;
    pkh_word[POS_P8] = p8_q;
  end

  // State, message latch and result capture at the edge leaving each state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      l_q       <= 8'h00;
      m_q       <= 3'b000;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      p4_q      <= 1'b0;
      p8_q      <= 1'b0;
      enc_lsw_q <= 8'h00;
      enc_msw_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        l_q <= msg_lsw;
        m_q <= msg_msw[2:0];
      end
      case (state_q)
        ST_P1:  p1_q <= alu_rslt[0];
        ST_P2:  p2_q <= alu_rslt[0];
        ST_P4:  p4_q <= alu_rslt[0];
        ST_P8:  p8_q <= alu_rslt[0];
        ST_PKL: enc_lsw_q <= pkl_word;
        ST_PKH: enc_msw_q <= pkh_word;
        ST_P0:  enc_lsw_q[POS_P0] <= alu_rslt[0];
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign enc_lsw   = enc_lsw_q;
  assign enc_msw   = enc_msw_q;
  assign alu_sc_in = 1'b0;

`ifdef SEQ_SELFCHECK_EN
  logic [7:0] ref_lsw, ref_msw;

  hamming_ref_enc u_ref_enc (
    .lsw     (l_q),
    .msw     (m_q),
    .enc_lsw (ref_lsw),
    .enc_msw (ref_msw)
  );

  assign chk_err = done && ({enc_msw_q, enc_lsw_q} != {ref_msw, ref_lsw});
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Self-checking bench for hamming_enc_seq with a behavioural ALU and a
// position-based Hamming reference model.
module tb_hamming_enc_seq;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] msg_lsw, msg_msw;
  logic       busy, done, chk_err, alu_sc_in;
  logic [7:0] enc_lsw, enc_msw, alu_a, alu_b, alu_rslt;
  logic [3:0] alu_op;
  logic [7:0] junk = 8'h00;
  logic [7:0] ref_l, ref_m, ref_enc_l, ref_enc_h;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  hamming_enc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .msg_lsw   (msg_lsw),
    .msg_msw   (msg_msw),
    .busy      (busy),
    .done      (done),
    .enc_lsw   (enc_lsw),
    .enc_msw   (enc_msw),
    .chk_err   (chk_err),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sc_in (alu_sc_in),
    .alu_rslt  (alu_rslt)
  );

  hamming_ref_enc u_ref (
    .lsw     (ref_l),
    .msw     (ref_m[2:0]),
    .enc_lsw (ref_enc_l),
    .enc_msw (ref_enc_h)
  );

  // Codeword built from the textbook rule: data in non-power-of-two positions,
  // parity k covers positions with bit k set, position 0 makes overall parity even.
  function automatic logic [15:0] model_cw(input logic [7:0] l, input logic [7:0] m);
    logic [10:0] d;
    logic [15:0] cw;
    logic        par;
    int          k;
    d  = {m[2:0], l};
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++) if ((pos & (1 << b)) != 0) par ^= cw[pos];
      cw[1 << b] = par;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  // Behavioural ALU; junk fills every bit the sequencer must ignore
  always @(negedge clk) junk = 8'($urandom);

  logic [15:0] cw_alu;
  always_comb begin
    cw_alu = model_cw(alu_a, alu_b);
    case (alu_op)
      4'b1001: alu_rslt = {junk[7:1], cw_alu[1]};
      4'b1010: alu_rslt = {junk[7:1], cw_alu[2]};
      4'b1011: alu_rslt = {junk[7:1], cw_alu[4]};
      4'b1100: alu_rslt = {junk[7:1], cw_alu[8]};
      4'b1101: alu_rslt = {cw_alu[7:5], junk[4], cw_alu[3], junk[2:0]};
      4'b1110: alu_rslt = {cw_alu[15:9], junk[0]};
      4'b1000: alu_rslt = {junk[7:1], ^{alu_a, alu_b}};
      default: alu_rslt = junk;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One encode; glitch pulses start with a different message in cycle +3
  task automatic run_encode(input logic [7:0] l, input logic [7:0] m, input bit glitch,
                            input string tag);
    logic [15:0] exp;
    logic [27:0] ops;
    int          lat;
    exp = model_cw(l, m);
    ops = '0;
    @(negedge clk);
    msg_lsw = l;
    msg_msw = m;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    ops   = {ops[23:0], alu_op};
    while (!done && lat < 20) begin
      if (glitch && lat == 3) begin
        start   = 1'b1;
        msg_lsw = ~l;
        msg_msw = ~m;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (lat < 7) ops = {ops[23:0], alu_op};
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " enc_lsw"}, {24'h0, enc_lsw}, {24'h0, exp[7:0]});
    chk({tag, " enc_msw"}, {24'h0, enc_msw}, {24'h0, exp[15:8]});
    chk({tag, " chk_err"}, {31'h0, chk_err}, 32'd0);
    chk({tag, " op trace"}, {4'h0, ops}, 32'h09ABCDE8);
    @(posedge clk); #1;
    chk({tag, " idle"}, {busy, done, alu_op, alu_a, alu_b}, 32'h0);
    chk({tag, " hold"}, {16'h0, enc_msw, enc_lsw}, {16'h0, exp});
  endtask

  initial begin
    logic [15:0] e;
    int          t;
    int          n_done;
    reset   = 1'b1;
    start   = 1'b0;
    msg_lsw = 8'h00;
    msg_msw = 8'h00;
    ref_l   = 8'h00;
    ref_m   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {busy, done, chk_err, alu_sc_in, alu_op, enc_lsw, enc_msw},
        32'h0);
    chk("reset alu operands", {16'h0, alu_a, alu_b}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    run_encode(8'h00, 8'h00, 1'b0, "zero");
    run_encode(8'hFF, 8'h07, 1'b0, "ones");
    chk("ones literal", {16'h0, enc_msw, enc_lsw}, 32'h0000FFFF);
    run_encode(8'h01, 8'h00, 1'b0, "d0");
    chk("d0 literal", {16'h0, enc_msw, enc_lsw}, 32'h0000000F);
    run_encode(8'h00, 8'h04, 1'b0, "d10");
    chk("d10 literal", {16'h0, enc_msw, enc_lsw}, 32'h00008117);
    run_encode(8'h00, 8'hF8, 1'b0, "ignored msw bits");
    chk("ignored literal", {16'h0, enc_msw, enc_lsw}, 32'h0);
    run_encode(8'h5A, 8'h03, 1'b1, "start glitch");

    // Back-to-back with start held high
    @(negedge clk);
    msg_lsw = 8'hFF;
    msg_msw = 8'h07;
    start   = 1'b1;
    @(posedge clk); #1;
    msg_lsw = 8'h01;
    msg_msw = 8'h00;
    t = 1;
    while (!done && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("b2b first latency", 32'(t), 32'd8);
    chk("b2b first enc", {16'h0, enc_msw, enc_lsw}, 32'h0000FFFF);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b restart busy", {31'h0, busy}, 32'd1);
    t = 1;
    while (!done && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("b2b done spacing", 32'(t), 32'd8);
    chk("b2b second enc", {16'h0, enc_msw, enc_lsw}, 32'h0000000F);
    @(posedge clk); #1;
    chk("b2b back to idle", {30'h0, busy, done}, 32'd0);

    // Reset while in PKH aborts the encode
    @(negedge clk);
    msg_lsw = 8'hFF;
    msg_msw = 8'h07;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("in PKH before reset", {28'h0, alu_op}, 32'hE);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort state", {14'h0, busy, done, enc_msw, enc_lsw}, 32'h0);
    n_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("abort no done", 32'(n_done), 32'd0);
    run_encode(8'h01, 8'h00, 1'b0, "after abort");

    // Randomized messages, plus cross-check of the golden encoder module
    for (int i = 0; i < 20; i++) begin
      logic [7:0] rl, rm;
      rl = 8'($urandom);
      rm = 8'($urandom);
      e  = model_cw(rl, rm);
      ref_l = rl;
      ref_m = rm;
      #1;
      chk($sformatf("ref_enc %0d", i), {16'h0, ref_enc_h, ref_enc_l}, {16'h0, e});
      run_encode(rl, rm, (i % 5) == 0, $sformatf("rand %0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_enc_seq.md
Name: hamming_enc_seq

Overview:
- Sequencer that drives the shared 8-bit ALU through its parity and pack ops to Hamming-encode one 11-bit message into a 16-bit SECDED codeword, held as LSW and MSW bytes.
- Issues one ALU op per cycle. Captures each result, inserts the parity bits into its own word registers, and returns the codeword with a done pulse.
- Sits between the program-level control (start/message) and the ALU. The ALU stays external, so the control can share it when the sequencer is idle.

Parameters:
ACCEPT_IN_DONE, 1, 1 = a start sampled in the DONE state is accepted, giving back-to-back encodes every 8 cycles; 0 = start is only accepted in IDLE.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request encode; sampled only when acceptance is allowed
msg_lsw  input  8  data bits d7..d0
msg_msw  input  8  data bits d10..d8 on [2:0]; [7:3] ignored
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse; enc_* valid from this cycle
enc_lsw  output  8  {d3,d2,d1,p4,d0,p2,p1,p0}
enc_msw  output  8  {d10..d4,p8}
chk_err  output  1  self-check mismatch; see Optional Feature
alu_op  output  4  ALU command
alu_a  output  8  ALU operand A
alu_b  output  8  ALU operand B
alu_sc_in  output  1  tied 0
alu_rslt  input  8  ALU result, combinational from alu_op/alu_a/alu_b

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - busy, done, chk_err = 0.
  - enc_lsw, enc_msw = 8'h00; internal message and parity registers = 0.
  - Reset mid-sequence aborts the encode with no done pulse.
- IDLE:
  - alu_op=4'b0000, alu_a=alu_b=0.
  - On start=1: latch msg_lsw→L and msg_msw[2:0]→M (upper bits 0), then go to P1.
- Sequence: one state per cycle. alu_rslt is captured at the edge that leaves each state.
  - P1: op 1001, A=L, B=M → p1 = rslt[0]
  - P2: op 1010, A=L, B=M → p2 = rslt[0]
  - P4: op 1011, A=L, B=M → p4 = rslt[0]
  - P8: op 1100, A=L, B=M → p8 = rslt[0]
  - PKL: op 1101, A=L, B=0 → enc_lsw = rslt with bits [4],[2],[1] overwritten by p4, p2, p1 and bit [0] forced to 0. Pack-slot contents from the ALU are never trusted.
  - PKH: op 1110, A=L, B=M → enc_msw = rslt with bit [0] overwritten by p8.
  - P0: op 1000, A=enc_lsw, B=enc_msw → enc_lsw[0] = rslt[0]
  - DONE: done=1 for exactly this cycle; next state is IDLE, or P1 if ACCEPT_IN_DONE=1 and start=1 (new message latched).
- Latency: start accepted at edge N → done high in cycle N+8. Throughput is 8 cycles per word when back-to-back.
- start while busy (except DONE with ACCEPT_IN_DONE=1) is ignored and not queued.
- enc_lsw/enc_msw are held stable from done until the PKL capture of the next encode. Intermediate values during a sequence are not valid.
- Only bit 0 of alu_rslt is consumed in the P* states. Zero/negative flags are not used.

Optional Feature:
SEQ_SELFCHECK_EN
- Defined: an internal combinational reference encoder computes the codeword from L/M. At DONE, chk_err = (enc ≠ reference), valid for the same cycle as done; it is cleared in all other cycles.
- Undefined: chk_err is tied 0 and no reference logic is built.

Decomposition:
- Package hamming_pkg holds:
  - the ALU op constants (OP_P0=4'b1000, OP_P1, OP_P2, OP_P4, OP_P8, OP_PKL=4'b1101, OP_PKH=4'b1110);
  - the state enum (IDLE, P1, P2, P4, P8, PKL, PKH, P0, DONE);
  - the bit-position constants (POS_P0=0, POS_P1=1, POS_P2=2, POS_P4=4 in LSW; POS_P8=0 in MSW).
- Sub-module hamming_ref_enc (pure combinational golden encoder) is used only under SEQ_SELFCHECK_EN and reused by the bench.

Test Plan:
- lsw=00, msw=00, start → done at cycle +8, enc_lsw=00, enc_msw=00, chk_err=0.
- lsw=FF, msw=07 → enc_lsw=FF, enc_msw=FF.
- lsw=01, msw=00 → enc_lsw=0F, enc_msw=00. lsw=00, msw=04 → enc_lsw=17, enc_msw=81. lsw=00, msw=F8 → 00/00 (ignored bits).
- start held high with ACCEPT_IN_DONE=1, messages FF/07 then 01/00 → done pulses exactly 8 cycles apart; results FF/FF then 0F/00. A start pulse in cycle +3 is ignored.
- reset asserted in PKH during encode of FF/07 → next cycle busy=0, enc=00/00, no done. A subsequent 01/00 encode is correct.
- alu_op trace per encode equals 1001,1010,1011,1100,1101,1110,1000, then 0000 in IDLE.
